// File: rtl/systolic_input_feeder.sv
// rtl/systolic_input_feeder.sv - loads an NxN tile from the unified buffer and streams it skewed into a systolic array
module systolic_input_feeder #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int MEM_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                hold,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [MEM_W-1:0]    mem_rd_data,
    output logic [N*DATA_W-1:0] a_out,
    output logic [N-1:0]        a_valid,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W  = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int STEP_W = $clog2(2 * N);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N * N - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   tile [N*N];
    logic [IDX_W-1:0]    rd_cnt;
    logic [IDX_W-1:0]    cap_idx;
    logic                cap_en;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   nxt_step;
    logic [N*DATA_W-1:0] nxt_a_out;
    logic [N-1:0]        nxt_a_valid;
    logic [IDX_W-1:0]    elem_idx;
    int                  s;

    if (MEM_W > DATA_W) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^mem_rd_data[MEM_W-1:DATA_W];
    end

    // Lane r shows A[r][s-r]; the word still being captured is forwarded so N=1 works.
    always_comb begin
        nxt_step    = (state == S_WAIT) ? '0 : step + STEP_W'(1);
        s           = int'(nxt_step);
        nxt_a_out   = '0;
        nxt_a_valid = '0;
        elem_idx    = '0;
        for (int r = 0; r < N; r++) begin
            if (s >= r && s - r < N) begin
                elem_idx       = IDX_W'(r * N + s - r);
                nxt_a_valid[r] = 1'b1;
                nxt_a_out[r*DATA_W +: DATA_W] = (cap_en && cap_idx == elem_idx) ?
                    mem_rd_data[DATA_W-1:0] : tile[elem_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            tile[cap_idx] <= mem_rd_data[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            a_out       <= '0;
            a_valid     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_cnt      <= '0;
            step        <= '0;
            cap_en      <= 1'b0;
            cap_idx     <= '0;
        end else begin
            cap_en  <= mem_rd_en;
            cap_idx <= rd_cnt;
            case (state)
                S_IDLE, S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (start) begin
                        state       <= S_LOAD;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= base_addr;
                        rd_cnt      <= '0;
                        busy        <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (rd_cnt == LAST_IDX) begin
                        mem_rd_en <= 1'b0;
                        state     <= S_WAIT;
                    end else begin
                        rd_cnt      <= rd_cnt + IDX_W'(1);
                        mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                    end
                end
                S_WAIT: begin
                    step    <= nxt_step;
                    a_out   <= nxt_a_out;
                    a_valid <= nxt_a_valid;
                    state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (!hold) begin
                        if (step == LAST_STEP) begin
                            a_out   <= '0;
                            a_valid <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            step    <= nxt_step;
                            a_out   <= nxt_a_out;
                            a_valid <= nxt_a_valid;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb/tb_systolic_input_feeder.sv - bench for systolic_input_feeder with N=2 and N=4 instances
module tb_systolic_input_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start2, hold2, start4, hold4;
    logic [5:0]  base2, base4;
    logic        rd_en2, rd_en4;
    logic [5:0]  addr2, addr4;
    logic [31:0] rd_data2 = '0;
    logic [31:0] rd_data4 = '0;
    logic [31:0] a_out2;
    logic [1:0]  a_valid2;
    logic        busy2, done2;
    logic [63:0] a_out4;
    logic [3:0]  a_valid4;
    logic        busy4, done4;

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;
    int sel;

    logic        o_rd_en, o_busy, o_done;
    logic [5:0]  o_addr;
    logic [63:0] o_a_out;
    logic [3:0]  o_a_valid;

    systolic_input_feeder #(.N(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .base_addr(base2), .hold(hold2),
        .mem_rd_en(rd_en2), .mem_rd_addr(addr2), .mem_rd_data(rd_data2),
        .a_out(a_out2), .a_valid(a_valid2), .busy(busy2), .done(done2)
    );

    systolic_input_feeder #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .base_addr(base4), .hold(hold4),
        .mem_rd_en(rd_en4), .mem_rd_addr(addr4), .mem_rd_data(rd_data4),
        .a_out(a_out4), .a_valid(a_valid4), .busy(busy4), .done(done4)
    );

    always @(posedge clk) begin
        if (rd_en2) rd_data2 <= mem[addr2];
        if (rd_en4) rd_data4 <= mem[addr4];
    end

    always_comb begin
        if (sel == 1) begin
            o_rd_en = rd_en4; o_addr = addr4; o_busy = busy4; o_done = done4;
            o_a_out = a_out4; o_a_valid = a_valid4;
        end else begin
            o_rd_en = rd_en2; o_addr = addr2; o_busy = busy2; o_done = done2;
            o_a_out = {32'b0, a_out2}; o_a_valid = {2'b0, a_valid2};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic hd, input logic [5:0] b);
        if (sel == 1) begin
            start4 = st; hold4 = hd; base4 = b;
        end else begin
            start2 = st; hold2 = hd; base2 = b;
        end
    endtask

    task automatic check_idle(input bit with_addr);
        check("idle_rd_en", o_rd_en, 0);
        check("idle_busy", o_busy, 0);
        check("idle_done", o_done, 0);
        check("idle_a_valid", o_a_valid, 0);
        check("idle_a_out", o_a_out, 0);
        if (with_addr) check("idle_rd_addr", o_addr, 0);
    endtask

    // Caller is at the negedge of the start cycle with the selected DUT idle or in done.
    task automatic run_tile(input int base, input logic [63:0] hold_pat, input logic [63:0] start_pat,
                            input bit chain, input int next_base);
        int n, nn, c, s, k;
        bit fin, chk_lanes, chk_addr;
        logic [63:0] e_out;
        logic [3:0]  e_valid;
        logic [5:0]  ea, e_addr;
        logic        e_rd, e_busy, e_done;
        n = (sel == 1) ? 4 : 2;
        nn = n * n;
        s = 0; c = 0; fin = 0;
        drive(1'b1, 1'b0, 6'(base));
        while (!fin && c < 60) begin
            @(negedge clk);
            c++;
            e_rd = 0; e_busy = 1; e_done = 0; e_out = '0; e_valid = '0;
            chk_lanes = 1; chk_addr = 0; e_addr = '0;
            if (c <= nn) begin
                e_rd = 1; chk_addr = 1; e_addr = 6'(base + c - 1);
            end else if (c == nn + 1) begin
                e_rd = 0;
            end else if (s < 2 * n - 1) begin
                for (int r = 0; r < n; r++) begin
                    k = s - r;
                    if (k >= 0 && k < n) begin
                        ea = 6'(base + r * n + k);
                        e_valid[r] = 1'b1;
                        e_out[r*16 +: 16] = mem[ea][15:0];
                    end
                end
                if (!hold_pat[c]) s++;
            end else begin
                e_busy = 0; e_done = 1; chk_lanes = 0; fin = 1;
            end
            if (fin) drive(chain, 1'b0, 6'(next_base));
            else drive(start_pat[c], hold_pat[c], 6'($urandom));
            check("rd_en", o_rd_en, e_rd);
            if (chk_addr) check("rd_addr", o_addr, e_addr);
            check("busy", o_busy, e_busy);
            check("done", o_done, e_done);
            if (chk_lanes) begin
                check("a_valid", o_a_valid, e_valid);
                check("a_out", o_a_out, e_out);
            end
        end
        check("tile_finished", fin, 1);
    endtask

    initial begin
        logic [63:0] hp, sp;
        int b;
        reset = 1'b1;
        start2 = 0; hold2 = 0; base2 = '0;
        start4 = 0; hold4 = 0; base4 = '0;
        sel = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        repeat (2) @(negedge clk);
        sel = 0; #1 check_idle(1);
        sel = 1; #1 check_idle(1);
        reset = 1'b0;
        sel = 0;
        @(negedge clk);

        // Basic N=2 tile
        mem[15] = 11; mem[16] = 12; mem[17] = 21; mem[18] = 22;
        run_tile(15, 64'h0, 64'h0, 0, 0);
        @(negedge clk);
        check_idle(0);

        // hold during cycles 7 and 8
        run_tile(15, (64'h1 << 7) | (64'h1 << 8), 64'h0, 0, 0);
        @(negedge clk);
        check_idle(0);

        // stray starts ignored, start in done cycle chains a new tile
        run_tile(15, 64'h0, (64'h1 << 3) | (64'h1 << 7), 1, 40);
        run_tile(40, 64'h0, 64'h0, 0, 0);
        @(negedge clk);
        check_idle(0);

        // address wrap
        mem[62] = 32'hAAAA_0101; mem[63] = 32'hBBBB_0202; mem[0] = 32'hCCCC_0303; mem[1] = 32'hDDDD_0404;
        run_tile(62, 64'h0, 64'h0, 0, 0);
        @(negedge clk);

        // reset mid-LOAD
        drive(1'b1, 1'b0, 6'd15);
        @(negedge clk);
        drive(1'b0, 1'b0, 6'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_rd_en", o_rd_en, 0);
        check("rst_busy", o_busy, 0);
        check("rst_a_valid", o_a_valid, 0);
        check("rst_done", o_done, 0);
        run_tile(15, 64'h0, 64'h0, 0, 0);
        @(negedge clk);

        // N=4, values 1..16 from base 0
        sel = 1;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        run_tile(0, 64'h0, 64'h0, 0, 0);
        @(negedge clk);
        check_idle(0);

        // randomized tiles on both instances
        for (int it = 0; it < 10; it++) begin
            sel = int'($urandom % 2);
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            b = int'($urandom % 64);
            hp = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_01FF_FFFF_FFFF;
            sp = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_01FF_FFFF_FFFF;
            run_tile(b, hp, sp, 0, 0);
            @(negedge clk);
            check_idle(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
